// File: rtl/mips_single_cycle_cpu.sv
// mips_single_cycle_cpu
//   Single-cycle 32-bit MIPS-subset core with an internal instruction ROM,
//   a 32 x 32 register file and a word-addressed data RAM. One instruction
//   commits on every rising clock edge while rst is high.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-low reset; while low the PC follows
//                  the pc input and all GPRs and data RAM words are cleared
//   pc             reset vector
//   t0_out..t5_out registers $8..$13   (combinational view)
//   s0_out..s5_out registers $16..$21  (combinational view)
//   memory3_out    data RAM word 3, byte address 12 (combinational view)
//   nextpc_out     next PC of the instruction currently addressed by the PC
//
// Supported: add/sub/and/or/slt (R-type), addi, lw, sw, beq, j. Every other
// opcode/funct retires as a NOP. IMEM_DEPTH and DMEM_DEPTH are powers of
// two, so the index bit-slices below wrap modulo the depth.
module mips_single_cycle_cpu #(
  parameter int IMEM_DEPTH = 64,
  parameter int DMEM_DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic [31:0] t0_out,
  output logic [31:0] t1_out,
  output logic [31:0] t2_out,
  output logic [31:0] t3_out,
  output logic [31:0] t4_out,
  output logic [31:0] t5_out,
  output logic [31:0] s0_out,
  output logic [31:0] s1_out,
  output logic [31:0] s2_out,
  output logic [31:0] s3_out,
  output logic [31:0] s4_out,
  output logic [31:0] s5_out,
  output logic [31:0] memory3_out,
  output logic [31:0] nextpc_out
);

  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  // Architectural state
  logic [31:0] pc_q, pc_d;
  logic [31:0] reg_q [32];
  logic [31:0] reg_d [32];
  logic [31:0] mem_q [DMEM_DEPTH];
  logic [31:0] mem_d [DMEM_DEPTH];

  // Fetch / decode
  logic [31:0]    instr;
  logic [5:0]     op;
  logic [4:0]     rs, rt, rd;
  logic [5:0]     funct;
  logic [31:0]    imm_sext;
  logic [31:0]    rs_val, rt_val;
  logic [31:0]    pc_plus4;
  logic [31:0]    branch_target;
  logic [31:0]    jump_target;
  logic [31:0]    mem_addr;
  logic [DAW-1:0] mem_idx;

  // Control / write-back
  logic        reg_we;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        mem_we;
  logic [31:0] nextpc;

  // Default program; unlisted words decode as NOP (all-zero R-type, funct 0).
  function automatic logic [31:0] rom_word(input logic [IAW-1:0] idx);
    logic [31:0] w;
    w = 32'h0000_0000;
    case (32'(idx))
      0:       w = 32'h2008_0005; // addi $t0,$0,5
      1:       w = 32'h2009_0003; // addi $t1,$0,3
      2:       w = 32'h0109_5020; // add  $t2,$t0,$t1
      3:       w = 32'h0109_5822; // sub  $t3,$t0,$t1
      4:       w = 32'h0109_6024; // and  $t4,$t0,$t1
      5:       w = 32'h0109_6825; // or   $t5,$t0,$t1
      6:       w = 32'h0128_802A; // slt  $s0,$t1,$t0
      7:       w = 32'hAC0A_000C; // sw   $t2,12($0)
      8:       w = 32'h8C11_000C; // lw   $s1,12($0)
      9:       w = 32'h1108_0001; // beq  $t0,$t0,+1
      10:      w = 32'h2012_0063; // addi $s2,$0,99
      11:      w = 32'h2012_0004; // addi $s2,$0,4
      12:      w = 32'h0800_000C; // j    12
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  assign instr    = rom_word(pc_q[IAW+1:2]);
  assign op       = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign funct    = instr[5:0];
  assign imm_sext = {{16{instr[15]}}, instr[15:0]};

  // $0 is never written, but the explicit zero keeps the read side honest.
  assign rs_val = (rs == 5'd0) ? 32'h0 : reg_q[rs];
  assign rt_val = (rt == 5'd0) ? 32'h0 : reg_q[rt];

  assign pc_plus4      = pc_q + 32'd4;
  assign branch_target = pc_plus4 + {imm_sext[29:0], 2'b00};
  assign jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};

  // Byte offset bits and everything above the RAM index are ignored.
  assign mem_addr = rs_val + imm_sext;
  assign mem_idx  = mem_addr[DAW+1:2];

  always_comb begin
    reg_we  = 1'b0;
    wr_addr = rd;
    wr_data = 32'h0;
    mem_we  = 1'b0;
    nextpc  = pc_plus4;
    case (op)
      OP_RTYPE: begin
        wr_addr = rd;
        case (funct)
          F_ADD: begin reg_we = 1'b1; wr_data = rs_val + rt_val; end
          F_SUB: begin reg_we = 1'b1; wr_data = rs_val - rt_val; end
          F_AND: begin reg_we = 1'b1; wr_data = rs_val & rt_val; end
          F_OR:  begin reg_we = 1'b1; wr_data = rs_val | rt_val; end
          F_SLT: begin
            reg_we  = 1'b1;
            wr_data = {31'h0, ($signed(rs_val) < $signed(rt_val))};
          end
          default: reg_we = 1'b0;
        endcase
      end
      OP_ADDI: begin
        reg_we  = 1'b1;
        wr_addr = rt;
        wr_data = rs_val + imm_sext;
      end
      OP_LW: begin
        reg_we  = 1'b1;
        wr_addr = rt;
        wr_data = mem_q[mem_idx];
      end
      OP_SW: mem_we = 1'b1;
      OP_BEQ: begin
        if (rs_val == rt_val) nextpc = branch_target;
      end
      OP_J: nextpc = jump_target;
      default: nextpc = pc_plus4;
    endcase
  end

  always_comb begin
    reg_d = reg_q;
    if (reg_we && (wr_addr != 5'd0)) reg_d[wr_addr] = wr_data;
  end

  always_comb begin
    mem_d = mem_q;
    if (mem_we) mem_d[mem_idx] = rt_val;
  end

  assign pc_d = nextpc;

  // Reset loads the PC from the pc port, so an in-flight instruction is
  // dropped and execution restarts at the reset vector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc_q <= pc;
    else      pc_q <= pc_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) reg_q[i] <= 32'h0;
    end else begin
      reg_q <= reg_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DMEM_DEPTH; i++) mem_q[i] <= 32'h0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign t0_out      = reg_q[8];
  assign t1_out      = reg_q[9];
  assign t2_out      = reg_q[10];
  assign t3_out      = reg_q[11];
  assign t4_out      = reg_q[12];
  assign t5_out      = reg_q[13];
  assign s0_out      = reg_q[16];
  assign s1_out      = reg_q[17];
  assign s2_out      = reg_q[18];
  assign s3_out      = reg_q[19];
  assign s4_out      = reg_q[20];
  assign s5_out      = reg_q[21];
  assign memory3_out = mem_q[3];
  assign nextpc_out  = nextpc;

  // Instruction and address bits this subset never looks at.
  logic unused_bits;
  assign unused_bits = ^{instr[10:6], mem_addr[31:DAW+2], mem_addr[1:0]};

endmodule

// File: tb/tb_mips_single_cycle_cpu.sv
// tb_mips_single_cycle_cpu
//   Self-checking bench for mips_single_cycle_cpu running the default ROM
//   program. Expected values are pushed to a queue when stimulus is applied
//   and popped when the matching DUT outputs are sampled (1 ns after the
//   committing edge, or mid-cycle during reset).
module tb_mips_single_cycle_cpu;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] t0_out, t1_out, t2_out, t3_out, t4_out, t5_out;
  logic [31:0] s0_out, s1_out, s2_out, s3_out, s4_out, s5_out;
  logic [31:0] memory3_out;
  logic [31:0] nextpc_out;

  logic [31:0] exp_q[$];
  int          total;
  int          bad;

  mips_single_cycle_cpu #(.IMEM_DEPTH(64), .DMEM_DEPTH(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .t0_out      (t0_out),
    .t1_out      (t1_out),
    .t2_out      (t2_out),
    .t3_out      (t3_out),
    .t4_out      (t4_out),
    .t5_out      (t5_out),
    .s0_out      (s0_out),
    .s1_out      (s1_out),
    .s2_out      (s2_out),
    .s3_out      (s3_out),
    .s4_out      (s4_out),
    .s5_out      (s5_out),
    .memory3_out (memory3_out),
    .nextpc_out  (nextpc_out)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #50 clk = ~clk;   // 100 ns period

  // Observation view: 0..5 = t0..t5, 6..11 = s0..s5, 12 = memory3
  function automatic logic [31:0] obs(input int i);
    case (i)
      0: return t0_out;   1: return t1_out;   2: return t2_out;
      3: return t3_out;   4: return t4_out;   5: return t5_out;
      6: return s0_out;   7: return s1_out;   8: return s2_out;
      9: return s3_out;  10: return s4_out;  11: return s5_out;
      default: return memory3_out;
    endcase
  endfunction

  function automatic string obs_name(input int i);
    case (i)
      0: return "t0";   1: return "t1";   2: return "t2";
      3: return "t3";   4: return "t4";   5: return "t5";
      6: return "s0";   7: return "s1";   8: return "s2";
      9: return "s3";  10: return "s4";  11: return "s5";
      default: return "memory3";
    endcase
  endfunction

  // Architectural values once the program has reached the halt loop.
  logic [31:0] final_vals [13];
  initial begin
    final_vals = '{32'd5, 32'd3, 32'd8, 32'd2, 32'd1, 32'd7,
                   32'd1, 32'd8, 32'd4, 32'd0, 32'd0, 32'd0, 32'd8};
  end

  // ---------------- driver tasks ----------------
  task automatic step_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] e;
    pc  = 32'd0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #5;
    for (int i = 0; i < 13; i++) exp_q.push_back(32'd0);
    exp_q.push_back(32'd4);
    for (int i = 0; i < 13; i++) begin
      e = exp_q.pop_front();
      total++;
      if (obs(i) !== e) begin
        bad++;
        $display("FAIL reset_%s: got %0d want %0d", obs_name(i), obs(i), e);
      end
    end
    e = exp_q.pop_front();
    total++;
    if (nextpc_out !== e) begin
      bad++;
      $display("FAIL reset_nextpc: got %0d want %0d", nextpc_out, e);
    end
    #5 rst = 1'b1;   // low for 10 ns
  endtask

  task automatic test_arith();
    logic [31:0] e;
    step_edges(6);
    for (int i = 0; i < 6; i++) exp_q.push_back(final_vals[i]);
    for (int i = 0; i < 6; i++) begin
      e = exp_q.pop_front();
      total++;
      if (obs(i) !== e) begin
        bad++;
        $display("FAIL arith_%s: got %0d want %0d", obs_name(i), obs(i), e);
      end
    end
  endtask

  task automatic test_compare_mem();
    logic [31:0] e;
    step_edges(1);
    exp_q.push_back(32'd1);
    e = exp_q.pop_front();
    total++;
    if (s0_out !== e) begin
      bad++; $display("FAIL slt_s0: got %0d want %0d", s0_out, e);
    end
    step_edges(1);
    exp_q.push_back(32'd8);
    e = exp_q.pop_front();
    total++;
    if (memory3_out !== e) begin
      bad++; $display("FAIL sw_memory3: got %0d want %0d", memory3_out, e);
    end
    step_edges(1);
    exp_q.push_back(32'd8);
    e = exp_q.pop_front();
    total++;
    if (s1_out !== e) begin
      bad++; $display("FAIL lw_s1: got %0d want %0d", s1_out, e);
    end
  endtask

  task automatic test_branch();
    logic [31:0] e;
    // PC = 36 (beq): taken branch skips word 10
    exp_q.push_back(32'd44);
    exp_q.push_back(32'd0);
    e = exp_q.pop_front();
    total++;
    if (nextpc_out !== e) begin
      bad++; $display("FAIL beq_nextpc: got %0d want %0d", nextpc_out, e);
    end
    e = exp_q.pop_front();
    total++;
    if (s2_out !== e) begin
      bad++; $display("FAIL beq_s2_before: got %0d want %0d", s2_out, e);
    end
    step_edges(1);   // edge 10: PC now 44
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd48);
    e = exp_q.pop_front();
    total++;
    if (s2_out !== e) begin
      bad++; $display("FAIL beq_s2_skip: got %0d want %0d", s2_out, e);
    end
    e = exp_q.pop_front();
    total++;
    if (nextpc_out !== e) begin
      bad++; $display("FAIL pc44_nextpc: got %0d want %0d", nextpc_out, e);
    end
    step_edges(1);   // edge 11
    exp_q.push_back(32'd4);
    e = exp_q.pop_front();
    total++;
    if (s2_out !== e) begin
      bad++; $display("FAIL addi_s2: got %0d want %0d", s2_out, e);
    end
  endtask

  task automatic test_halt();
    logic [31:0] e;
    int cycles;
    cycles = $urandom_range(3, 6);
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < 13; i++) exp_q.push_back(final_vals[i]);
      exp_q.push_back(32'd48);
      for (int i = 0; i < 13; i++) begin
        e = exp_q.pop_front();
        total++;
        if (obs(i) !== e) begin
          bad++;
          $display("FAIL halt_%s cyc%0d: got %0d want %0d", obs_name(i), c, obs(i), e);
        end
      end
      e = exp_q.pop_front();
      total++;
      if (nextpc_out !== e) begin
        bad++; $display("FAIL halt_nextpc cyc%0d: got %0d want %0d", c, nextpc_out, e);
      end
      step_edges(1);
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] e;
    pc = 32'd0;
    #10 rst = 1'b0;
    #5  rst = 1'b1;
    step_edges(4);
    for (int i = 0; i < 4; i++) exp_q.push_back(final_vals[i]);
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      total++;
      if (obs(i) !== e) begin
        bad++;
        $display("FAIL prereset_%s: got %0d want %0d", obs_name(i), obs(i), e);
      end
    end
    // Pulse reset between edges 4 and 5.
    #10 rst = 1'b0;
    #5;
    for (int i = 0; i < 13; i++) exp_q.push_back(32'd0);
    exp_q.push_back(32'd4);
    for (int i = 0; i < 13; i++) begin
      e = exp_q.pop_front();
      total++;
      if (obs(i) !== e) begin
        bad++;
        $display("FAIL midreset_%s: got %0d want %0d", obs_name(i), obs(i), e);
      end
    end
    e = exp_q.pop_front();
    total++;
    if (nextpc_out !== e) begin
      bad++; $display("FAIL midreset_nextpc: got %0d want %0d", nextpc_out, e);
    end
    #5 rst = 1'b1;
    step_edges(11);
    for (int i = 0; i < 13; i++) exp_q.push_back(final_vals[i]);
    exp_q.push_back(32'd48);
    for (int i = 0; i < 13; i++) begin
      e = exp_q.pop_front();
      total++;
      if (obs(i) !== e) begin
        bad++;
        $display("FAIL rerun_%s: got %0d want %0d", obs_name(i), obs(i), e);
      end
    end
    e = exp_q.pop_front();
    total++;
    if (nextpc_out !== e) begin
      bad++; $display("FAIL rerun_nextpc: got %0d want %0d", nextpc_out, e);
    end
  endtask

  task automatic test_alt_start();
    logic [31:0] e;
    pc = 32'd8;
    #10 rst = 1'b0;
    #5;
    exp_q.push_back(32'd12);
    e = exp_q.pop_front();
    total++;
    if (nextpc_out !== e) begin
      bad++; $display("FAIL alt_reset_nextpc: got %0d want %0d", nextpc_out, e);
    end
    #5 rst = 1'b1;
    step_edges(6);   // add, sub, and, or, slt, sw on zero operands
    for (int i = 0; i < 13; i++) exp_q.push_back(32'd0);
    exp_q.push_back(32'd36);
    for (int i = 0; i < 13; i++) begin
      e = exp_q.pop_front();
      total++;
      if (obs(i) !== e) begin
        bad++;
        $display("FAIL alt_%s: got %0d want %0d", obs_name(i), obs(i), e);
      end
    end
    e = exp_q.pop_front();
    total++;
    if (nextpc_out !== e) begin
      bad++; $display("FAIL alt_nextpc: got %0d want %0d", nextpc_out, e);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    pc    = 32'd0;
    test_reset();
    test_arith();
    test_compare_mem();
    test_branch();
    test_halt();
    test_mid_reset();
    test_alt_start();
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover: got %0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
